peripheral_msi_sync2_ptx_wb: RTL and testbench

Source-side end of the toggle-handshake pulse crossing used by the MSI Wishbone CDC path. Converts single-cycle request pulses in the `wb_clk_i` domain into level transitions on `tgl_o`, which the destination domain samples with a two-flop synchronizer and edge detector. The destination returns each observed transition on `ack_tgl_i`. This block synchronizes that acknowledge, completes the handshake, and gates further requests until completion.

---
 rtl/peripheral_msi_sync2_ptx_wb.sv | 122 ++++++++++++
 tb/tb_peripheral_msi_sync2_ptx_wb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_msi_sync2_ptx_wb.sv
// Source side of the MSI toggle-handshake pulse crossing: request pulses become tgl_o
// transitions; the returned ack toggle is synchronized and completes the handshake.
// Optional request queue enabled by defining PERIPHERAL_MSI_SYNC2_PTX_PEND_EN.
module peripheral_msi_sync2_ptx_wb #(
   parameter int CNT_W = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             pulse_i,
   input  logic             ack_tgl_i,
   output logic             tgl_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             drop_o,
   output logic             ack_err_o,
   output logic [CNT_W-1:0] pend_o
);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t state, state_nx;
   logic   a1, a2, a3;
   logic   ack_e;
   logic   tgl_nx, done_nx, drop_nx, err_nx;

`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   logic [CNT_W-1:0] pend_q, pend_nx;
`endif

   // a1 is the metastability catcher; a2/a3 give a clean edge detect.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         a1 <= 1'b0;
         a2 <= 1'b0;
         a3 <= 1'b0;
      end else begin
         a1 <= ack_tgl_i;
         a2 <= a1;
         a3 <= a2;
      end
   end

   assign ack_e = a2 ^ a3;

   always_comb begin
      state_nx = state;
      tgl_nx   = tgl_o;
      done_nx  = 1'b0;
      drop_nx  = 1'b0;
      err_nx   = 1'b0;
`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
      pend_nx  = pend_q;
`endif
      case (state)
         IDLE: begin
            err_nx = ack_e;
            if (pulse_i) begin
               tgl_nx   = ~tgl_o;
               state_nx = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_e) begin
               done_nx = 1'b1;
`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
               // A queued entry is re-issued first; a coincident pulse takes its slot.
               if (pend_q != '0) begin
                  tgl_nx = ~tgl_o;
                  if (!pulse_i) pend_nx = pend_q - CNT_W'(1);
               end else if (pulse_i) begin
                  tgl_nx = ~tgl_o;
               end else begin
                  state_nx = IDLE;
               end
`else
               if (pulse_i) tgl_nx = ~tgl_o;
               else         state_nx = IDLE;
`endif
            end else if (pulse_i) begin
`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
               if (pend_q == PEND_MAX) drop_nx = 1'b1;
               else                    pend_nx = pend_q + CNT_W'(1);
`else
               drop_nx = 1'b1;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         tgl_o     <= 1'b0;
         done_o    <= 1'b0;
         drop_o    <= 1'b0;
         ack_err_o <= 1'b0;
      end else begin
         state     <= state_nx;
         tgl_o     <= tgl_nx;
         done_o    <= done_nx;
         drop_o    <= drop_nx;
         ack_err_o <= err_nx;
      end
   end

   assign busy_o = (state == WAIT_ACK);

`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) pend_q <= '0;
      else          pend_q <= pend_nx;
   end

   assign pend_o = pend_q;
`else
   assign pend_o = '0;
`endif

endmodule

// File: tb/tb_peripheral_msi_sync2_ptx_wb.sv
// Bench for peripheral_msi_sync2_ptx_wb: vector table, directed corner cases and a
// randomized run against a queue-based handshake model. Honours PERIPHERAL_MSI_SYNC2_PTX_PEND_EN.
module tb_peripheral_msi_sync2_ptx_wb;

`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
   localparam int CNT_W_TB = 2;
   localparam int CAP      = (1 << CNT_W_TB) - 1;
   localparam bit PEND     = 1'b1;
`else
   localparam int CNT_W_TB = 4;
   localparam int CAP      = 0;
   localparam bit PEND     = 1'b0;
`endif

   logic                wb_clk_i = 1'b0;
   logic                wb_rst_i = 1'b0;
   logic                pulse_i = 1'b0;
   logic                ack_tgl_i = 1'b0;
   logic                tgl_o, busy_o, done_o, drop_o, ack_err_o;
   logic [CNT_W_TB-1:0] pend_o;

   int checks = 0;
   int errors = 0;

   peripheral_msi_sync2_ptx_wb #(.CNT_W(CNT_W_TB)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .pulse_i   (pulse_i),
      .ack_tgl_i (ack_tgl_i),
      .tgl_o     (tgl_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .drop_o    (drop_o),
      .ack_err_o (ack_err_o),
      .pend_o    (pend_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic pulse;
      logic ack;
      logic tgl;
      logic busy;
      logic done;
      logic drop;
      logic err;
      int   pend;
   } vec_t;

   vec_t vecs[20];

   // Reference model: handshake flags plus a pending count with capacity CAP.
   logic m_tgl, m_busy, m_done, m_drop, m_err;
   int   m_pend;
   logic ack_hist[$];

   task automatic applyStimulus(input logic p, input logic a);
      pulse_i   = p;
      ack_tgl_i = a;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic t, input logic b, input logic d,
                              input logic dr, input logic e, input int p);
      checks++;
      if ({tgl_o, busy_o, done_o, drop_o, ack_err_o} !== {t, b, d, dr, e} || int'(pend_o) != p) begin
         errors++;
         $display("[TB] FAIL %s: got tgl=%b busy=%b done=%b drop=%b err=%b pend=%0d, expected tgl=%b busy=%b done=%b drop=%b err=%b pend=%0d",
                  name, tgl_o, busy_o, done_o, drop_o, ack_err_o, pend_o, t, b, d, dr, e, p);
      end
   endtask

   task automatic doReset();
      pulse_i   = 1'b0;
      ack_tgl_i = 1'b0;
      wb_rst_i  = 1'b1;
      repeat (2) @(posedge wb_clk_i);
      #2;
      wb_rst_i = 1'b0;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic modelReset();
      m_tgl = 0; m_busy = 0; m_done = 0; m_drop = 0; m_err = 0; m_pend = 0;
      ack_hist = {1'b0, 1'b0, 1'b0};
   endtask

   // The ack change is visible to the handshake two edges after it is first sampled.
   task automatic modelStep(input logic p, input logic a);
      logic seen;
      seen = ack_hist[ack_hist.size()-2] != ack_hist[ack_hist.size()-3];
      ack_hist.push_back(a);
      if (ack_hist.size() > 4) void'(ack_hist.pop_front());
      m_done = 0; m_drop = 0; m_err = 0;
      if (!m_busy) begin
         m_err = seen;
         if (p) begin
            m_tgl  = ~m_tgl;
            m_busy = 1;
         end
      end else if (seen) begin
         m_done = 1;
         if (m_pend > 0) begin
            m_pend--;
            m_tgl = ~m_tgl;
            if (p) m_pend++;
         end else if (p) begin
            m_tgl = ~m_tgl;
         end else begin
            m_busy = 0;
         end
      end else if (p) begin
         if (m_pend < CAP) m_pend++;
         else              m_drop = 1;
      end
   endtask

   task automatic ackRound(input string name, input logic t, input logic b, input int p);
      ack_tgl_i = ~ack_tgl_i;
      applyStimulus(1'b0, ack_tgl_i);
      applyStimulus(1'b0, ack_tgl_i);
      applyStimulus(1'b0, ack_tgl_i);
      checkOutput(name, t, b, 1'b1, 1'b0, 1'b0, p);
   endtask

   initial begin
      int dropCount;
      int dly;
      logic rp;
      logic ra;

      vecs[0]  = '{1, 0, 1, 1, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 1, 1, 0, 0, 0, 0};
      vecs[2]  = '{0, 1, 1, 1, 0, 0, 0, 0};
      vecs[3]  = '{0, 1, 1, 1, 0, 0, 0, 0};
      vecs[4]  = '{0, 1, 1, 0, 1, 0, 0, 0};
      vecs[5]  = '{0, 1, 1, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 1, 0, 0, 0, 0, 0};
      vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
      vecs[9]  = '{0, 0, 1, 0, 0, 0, 0, 0};
      vecs[10] = '{1, 0, 0, 1, 0, 0, 0, 0};
      vecs[11] = '{0, 1, 0, 1, 0, 0, 0, 0};
      vecs[12] = '{0, 1, 0, 1, 0, 0, 0, 0};
      vecs[13] = '{1, 1, 1, 1, 1, 0, 0, 0};
      vecs[14] = '{0, 1, 1, 1, 0, 0, 0, 0};
`ifdef PERIPHERAL_MSI_SYNC2_PTX_PEND_EN
      vecs[15] = '{1, 1, 1, 1, 0, 0, 0, 1};
      vecs[16] = '{0, 0, 1, 1, 0, 0, 0, 1};
      vecs[17] = '{0, 0, 1, 1, 0, 0, 0, 1};
      vecs[18] = '{0, 0, 0, 1, 1, 0, 0, 0};
      vecs[19] = '{0, 0, 0, 1, 0, 0, 0, 0};
`else
      vecs[15] = '{1, 1, 1, 1, 0, 1, 0, 0};
      vecs[16] = '{0, 0, 1, 1, 0, 0, 0, 0};
      vecs[17] = '{0, 0, 1, 1, 0, 0, 0, 0};
      vecs[18] = '{0, 0, 1, 0, 1, 0, 0, 0};
      vecs[19] = '{0, 0, 1, 0, 0, 0, 0, 0};
`endif

      $display("[TB] start, queue capacity %0d", CAP);
      doReset();
      checkOutput("reset_state", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].pulse, vecs[i].ack);
         checkOutput($sformatf("vec%0d", i), vecs[i].tgl, vecs[i].busy, vecs[i].done,
                     vecs[i].drop, vecs[i].err, vecs[i].pend);
      end

      // Requests while busy: queued up to capacity, the rest dropped.
      doReset();
      dropCount = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0);
         if (drop_o) dropCount++;
      end
      applyStimulus(1'b0, 1'b0);
      checks++;
      if (dropCount != (4 - CAP) || int'(pend_o) != CAP || busy_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_pulses: got drops=%0d pend=%0d busy=%b, expected drops=%0d pend=%0d busy=1",
                  dropCount, pend_o, busy_o, 4 - CAP, CAP);
      end
      for (int i = CAP; i > 0; i--)
         ackRound($sformatf("reissue_pend%0d", i - 1), ((CAP - i) % 2 == 0) ? 1'b0 : 1'b1, 1'b1, i - 1);
      ackRound("final_done", (CAP % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 0);
      applyStimulus(1'b0, ack_tgl_i);
      checkOutput("done_single", (CAP % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Asynchronous reset mid-handshake clears outputs before any clock edge.
      doReset();
      applyStimulus(1'b1, 1'b0);
      if (PEND) begin
         applyStimulus(1'b1, 1'b0);
         applyStimulus(1'b1, 1'b0);
         checkOutput("pre_reset", 1, 1, 0, 0, 0, 2);
      end else begin
         checkOutput("pre_reset", 1, 1, 0, 0, 0, 0);
      end
      #2 wb_rst_i = 1'b1;
      #1 checkOutput("async_reset", 0, 0, 0, 0, 0, 0);
      #3 wb_rst_i = 1'b0;
      @(posedge wb_clk_i);
      #1;

      // Randomized run: the bench plays the destination, echoing tgl_o after a random delay.
      doReset();
      modelReset();
      ra  = 1'b0;
      dly = 0;
      for (int i = 0; i < 3000; i++) begin
         rp = ($urandom_range(0, 3) == 0);
         if (ra != tgl_o) begin
            if (dly == 0) ra = tgl_o;
            else          dly--;
         end else begin
            dly = $urandom_range(0, 4);
         end
         modelStep(rp, ra);
         applyStimulus(rp, ra);
         checkOutput($sformatf("random%0d", i), m_tgl, m_busy, m_done, m_drop, m_err, m_pend);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
